// File: rtl/rv_bu_pkg.sv
// Shared types and constants for the RV bus arbiter / sequencer.
package rv_bu_pkg;

  typedef enum logic [1:0] {
    BU_IDLE,
    BU_CMD,
    BU_WAIT,
    BU_RESP
  } bu_state_t;

  typedef enum logic {
    OWN_INSTR,
    OWN_DATA
  } bu_owner_t;

  // Fetches always transfer a full word.
  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/rv_bus_arb_pick.sv
// Combinational priority picker: data wins unless only a fetch is pending or
// the data-grant streak has hit its limit while a fetch waits.
module rv_bus_arb_pick
  import rv_bu_pkg::*;
#(
  parameter int MAX_DGRANT = 4
) (
  input  logic       i_req_i,
  input  logic       d_req_i,
  input  logic [3:0] dgrant_cnt_i,
  output bu_owner_t  owner_o,
  output logic       grant_o
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DGRANT);

  logic fetch_wins;

  assign fetch_wins = i_req_i && (!d_req_i || (dgrant_cnt_i == MAX_CNT));
  assign grant_o    = i_req_i || d_req_i;
  assign owner_o    = fetch_wins ? OWN_INSTR : OWN_DATA;

endmodule

// File: rtl/rv_bus_arb.sv
// rv_bus_arb: shares one memory bus between the instruction-fetch and the
// load/store requesters. Owns the bus FSM, the fetch starvation guard and the
// ack timeout; returns exactly one completion per accepted request.
module rv_bus_arb
  import rv_bu_pkg::*;
#(
  parameter int MAX_DGRANT = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        ads,
  output logic        rd_wr_n,
  output logic        i_dn,
  output logic [31:0] addr,
  output logic [3:0]  be,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  input  logic        ack,
  output logic        busy
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DGRANT);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  bu_state_t  state_q;
  bu_owner_t  owner_q;
  logic [3:0] dgrant_q;
  logic [3:0] dgrant_d;
  logic [7:0] tcnt_q;

  bu_owner_t  pick_owner;
  logic       pick_grant;
  logic       fin;
  logic       fin_err;

  rv_bus_arb_pick #(
    .MAX_DGRANT(MAX_DGRANT)
  ) u_pick (
    .i_req_i     (i_req),
    .d_req_i     (d_req),
    .dgrant_cnt_i(dgrant_q),
    .owner_o     (pick_owner),
    .grant_o     (pick_grant)
  );

  // Next data-grant streak; only committed when a grant is issued from IDLE.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    dgrant_d = dgrant_q;
    if ((pick_owner == OWN_INSTR) || !i_req) begin
      dgrant_d = '0;
    end else if (dgrant_q != MAX_CNT) begin
      dgrant_d = dgrant_q + 4'd1;
    end
  end

  // Transaction end: ack in CMD/WAIT wins; otherwise abort on the last WAIT cycle.
  always_comb begin
    fin     = 1'b0;
    fin_err = 1'b0;
    case (state_q)
      BU_CMD: fin = ack;
      BU_WAIT: begin
        if (ack) begin
          fin = 1'b1;
        end else if (tcnt_q == TO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bus FSM: grant in IDLE, strobe in CMD, wait for ack or timeout, pulse done in RESP.
  // NOTE: the async reset clears every register, read-data holding registers included,
  // so an aborted transaction leaves no stale completion behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BU_IDLE;
      owner_q  <= OWN_DATA;
      dgrant_q <= '0;
      tcnt_q   <= '0;
      ads      <= 1'b0;
      rd_wr_n  <= 1'b1;
      i_dn     <= 1'b1;
      addr     <= '0;
      be       <= '0;
      wr_data  <= '0;
      i_done   <= 1'b0;
      d_done   <= 1'b0;
      i_err    <= 1'b0;
      d_err    <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees this cycle's state.
      case (state_q)
        BU_IDLE: begin
          if (pick_grant) begin
            owner_q  <= pick_owner;
            dgrant_q <= dgrant_d;
            ads      <= 1'b1;
            state_q  <= BU_CMD;
            if (pick_owner == OWN_INSTR) begin
              addr    <= i_addr;
              rd_wr_n <= 1'b1;
              i_dn    <= 1'b1;
              be      <= BE_WORD;
            end else begin
              addr    <= d_addr;
              rd_wr_n <= ~d_we;
              i_dn    <= 1'b0;
              be      <= d_be;
              wr_data <= d_wdata;
            end
          end
        end
        BU_CMD: begin
          ads <= 1'b0;
          if (fin) begin
            state_q <= BU_RESP;
          end else begin
            tcnt_q  <= '0;
            state_q <= BU_WAIT;
          end
        end
        BU_WAIT: begin
          tcnt_q <= tcnt_q + 8'd1;
          if (fin) begin
            state_q <= BU_RESP;
          end
        end
        BU_RESP: begin
          i_done  <= 1'b0;
          d_done  <= 1'b0;
          state_q <= BU_IDLE;
        end
        default: state_q <= BU_IDLE;
      endcase

      if (fin) begin
        if (owner_q == OWN_INSTR) begin
          i_done <= 1'b1;
          i_err  <= fin_err;
          if (!fin_err) begin
            i_rdata <= rd_data;
          end
        end else begin
          d_done <= 1'b1;
          d_err  <= fin_err;
          if (rd_wr_n && !fin_err) begin
            d_rdata <= rd_data;
          end
        end
      end
    end
  end

  // Busy whenever a transaction is in flight.
  assign busy = (state_q != BU_IDLE);

endmodule

// File: tb/tb_rv_bus_arb.sv
// Bench for rv_bus_arb: a transaction-timeline model of the bus checked every
// cycle, plus directed scenarios with literal expectations.
module tb_rv_bus_arb;

  localparam int MAX_DGRANT = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, ack;
  logic [31:0] i_addr, d_addr, d_wdata, rd_data;
  logic [3:0]  d_be;
  logic        i_done, i_err, d_done, d_err, ads, rd_wr_n, i_dn, busy;
  logic [31:0] i_rdata, d_rdata, addr, wr_data;
  logic [3:0]  be;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Bus responder controls (written by stimulus only).
  int          ack_delay  = 0;
  logic [31:0] resp_data  = 32'h0;
  logic        inject_ack = 1'b0;

  rv_bus_arb #(
    .MAX_DGRANT(MAX_DGRANT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_req  (i_req),
    .i_addr (i_addr),
    .i_done (i_done),
    .i_rdata(i_rdata),
    .i_err  (i_err),
    .d_req  (d_req),
    .d_we   (d_we),
    .d_addr (d_addr),
    .d_be   (d_be),
    .d_wdata(d_wdata),
    .d_done (d_done),
    .d_rdata(d_rdata),
    .d_err  (d_err),
    .ads    (ads),
    .rd_wr_n(rd_wr_n),
    .i_dn   (i_dn),
    .addr   (addr),
    .be     (be),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .ack    (ack),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for ads (0), i_done (1) or d_done (2); n = negedges waited.
  task automatic wait_sig(input int which, input int budget, output int n);
    logic s;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      s = (which == 0) ? ads : ((which == 1) ? i_done : d_done);
      if (s === 1'b1) break;
      if (n >= budget) begin
        check("wait_bound", 32'(s), 32'd1);
        break;
      end
    end
  endtask

  // Bus responder: ack ack_delay cycles after the ads cycle (0 = same cycle,
  // negative = never); inject_ack forces ack for one stray cycle.
  initial begin : responder
    int wl;
    wl      = -1;
    ack     = 1'b0;
    rd_data = 32'h0BAD_F00D;
    forever begin
      @(posedge clk);
      #1;
      if (reset) wl = -1;
      else if (ads === 1'b1) wl = ack_delay;
      else if (wl > 0) wl--;
      ack = (wl == 0) || inject_ack;
      if (wl == 0) wl = -1;
      rd_data = ack ? resp_data : 32'h0BAD_F00D;
    end
  end

  // Transaction-timeline model: a grant at cycle 0 puts ads at cycle 1; done
  // comes the cycle after the first ack seen from cycle 1 on, or at cycle
  // TIMEOUT+2 when no ack ever arrives; the cycle after done is idle.
  bit          m_active = 1'b0;
  bit          m_fetch  = 1'b0;
  bit          m_read   = 1'b1;
  int          m_k      = 0;
  int          m_done_k = -1;
  int          m_streak = 0;
  logic [31:0] e_addr   = '0;
  logic [3:0]  e_be     = '0;
  logic [31:0] e_wdata  = '0;
  logic        e_rdwrn  = 1'b1;
  logic        e_idn    = 1'b1;
  logic [31:0] e_irdata = '0;
  logic        e_ierr   = 1'b0;
  logic [31:0] e_drdata = '0;
  logic        e_derr   = 1'b0;

  initial begin : model_compare
    logic x_ads, x_busy, x_idone, x_ddone;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_active = 1'b0;
        m_streak = 0;
        e_addr   = '0;
        e_be     = '0;
        e_wdata  = '0;
        e_rdwrn  = 1'b1;
        e_idn    = 1'b1;
        e_irdata = '0;
        e_ierr   = 1'b0;
        e_drdata = '0;
        e_derr   = 1'b0;
      end
      x_ads   = m_active && (m_k == 1);
      x_busy  = m_active;
      x_idone = m_active && m_fetch && (m_k == m_done_k);
      x_ddone = m_active && !m_fetch && (m_k == m_done_k);
      check("m_ads", 32'(ads), 32'(x_ads));
      check("m_busy", 32'(busy), 32'(x_busy));
      check("m_i_done", 32'(i_done), 32'(x_idone));
      check("m_d_done", 32'(d_done), 32'(x_ddone));
      check("m_addr", addr, e_addr);
      check("m_be", 32'(be), 32'(e_be));
      check("m_wr_data", wr_data, e_wdata);
      check("m_rd_wr_n", 32'(rd_wr_n), 32'(e_rdwrn));
      check("m_i_dn", 32'(i_dn), 32'(e_idn));
      check("m_i_rdata", i_rdata, e_irdata);
      check("m_i_err", 32'(i_err), 32'(e_ierr));
      check("m_d_rdata", d_rdata, e_drdata);
      check("m_d_err", 32'(d_err), 32'(e_derr));

      if (!reset) begin
        if (m_active) begin
          if ((m_done_k > 0) && (m_k == m_done_k)) begin
            m_active = 1'b0;
          end else begin
            if (m_done_k < 0) begin
              if (ack === 1'b1) begin
                m_done_k = m_k + 1;
                if (m_fetch) begin
                  e_ierr   = 1'b0;
                  e_irdata = rd_data;
                end else begin
                  e_derr = 1'b0;
                  if (m_read) e_drdata = rd_data;
                end
              end else if (m_k == TIMEOUT + 1) begin
                m_done_k = m_k + 1;
                if (m_fetch) e_ierr = 1'b1;
                else e_derr = 1'b1;
              end
            end
            m_k++;
          end
        end else if (i_req || d_req) begin
          m_fetch = i_req && (!d_req || (m_streak == MAX_DGRANT));
          if (m_fetch) begin
            m_streak = 0;
            e_addr   = i_addr;
            e_be     = 4'hF;
            e_rdwrn  = 1'b1;
            e_idn    = 1'b1;
            m_read   = 1'b1;
          end else begin
            m_streak = i_req ? ((m_streak < MAX_DGRANT) ? m_streak + 1 : MAX_DGRANT) : 0;
            e_addr   = d_addr;
            e_be     = d_be;
            e_wdata  = d_wdata;
            e_rdwrn  = !d_we;
            e_idn    = 1'b0;
            m_read   = !d_we;
          end
          m_active = 1'b1;
          m_k      = 1;
          m_done_k = -1;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  n;
    int  last_ads;
    bit  exp_fetch [10];
    exp_fetch = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    reset   = 1'b1;
    i_req   = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    i_addr  = '0;
    d_addr  = '0;
    d_be    = '0;
    d_wdata = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ads", 32'(ads), 32'd0);
    check("rst_rd_wr_n", 32'(rd_wr_n), 32'd1);
    check("rst_i_dn", 32'(i_dn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b0;

    // Single zero-wait fetch.
    ack_delay = 0;
    resp_data = 32'hDEAD_BEEF;
    tick();
    i_addr = 32'h100;
    i_req  = 1'b1;
    wait_sig(0, 10, n);
    check("t1_ads_lat", 32'(n), 32'd2);
    check("t1_addr", addr, 32'h100);
    check("t1_rd_wr_n", 32'(rd_wr_n), 32'd1);
    check("t1_i_dn", 32'(i_dn), 32'd1);
    check("t1_be", 32'(be), 32'hF);
    wait_sig(1, 10, n);
    check("t1_done_lat", 32'(n), 32'd1);
    check("t1_i_rdata", i_rdata, 32'hDEAD_BEEF);
    check("t1_i_err", 32'(i_err), 32'd0);
    tick();
    i_req = 1'b0;

    // Data write with wait states.
    ack_delay = 3;
    tick();
    d_we    = 1'b1;
    d_addr  = 32'h2000;
    d_be    = 4'h3;
    d_wdata = 32'h1234;
    d_req   = 1'b1;
    wait_sig(0, 10, n);
    check("t2_addr", addr, 32'h2000);
    check("t2_rd_wr_n", 32'(rd_wr_n), 32'd0);
    check("t2_i_dn", 32'(i_dn), 32'd0);
    check("t2_be", 32'(be), 32'h3);
    check("t2_wr_data", wr_data, 32'h1234);
    wait_sig(2, 20, n);
    check("t2_done_after_ads", 32'(n), 32'd4);
    check("t2_d_err", 32'(d_err), 32'd0);
    check("t2_i_done", 32'(i_done), 32'd0);
    tick();
    d_req = 1'b0;
    d_we  = 1'b0;

    // Both requesters saturated: D,D,D,D,I,D,D,D,D,I.
    ack_delay = 0;
    resp_data = 32'h5A5A_0003;
    tick();
    d_addr = 32'h3000;
    d_be   = 4'hF;
    i_addr = 32'h800;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int g = 0; g < 10; g++) begin
      wait_sig(0, 10, n);
      check("t3_order_i_dn", 32'(i_dn), 32'(exp_fetch[g]));
      check("t3_addr", addr, exp_fetch[g] ? 32'h800 : 32'h3000);
      if (g > 0) check("t3_gap", 32'(n), 32'd3);
    end
    wait_sig(1, 10, n);
    tick();
    i_req = 1'b0;
    d_req = 1'b0;

    // Data read never acked -> timeout; stray ack afterwards is ignored.
    ack_delay = -1;
    tick();
    d_addr = 32'h4000;
    d_req  = 1'b1;
    wait_sig(0, 10, n);
    wait_sig(2, 40, n);
    // The grant cycle is one cycle before the ads cycle.
    check("t4_grant_to_done", 32'(n + 1), 32'(TIMEOUT + 2));
    check("t4_d_err", 32'(d_err), 32'd1);
    inject_ack = 1'b1;
    tick();
    d_req = 1'b0;
    @(negedge clk);
    inject_ack = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("t4_no_extra_done", 32'(d_done), 32'd0);
    end
    check("t4_idle", 32'(busy), 32'd0);

    // Reset in the middle of a WAIT, then a clean fetch.
    tick();
    i_addr = 32'h400;
    i_req  = 1'b1;
    wait_sig(0, 10, n);
    repeat (3) @(negedge clk);
    check("t5_busy_before", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t5_ads", 32'(ads), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_i_done", 32'(i_done), 32'd0);
    tick();
    tick();
    reset     = 1'b0;
    ack_delay = 0;
    resp_data = 32'hCAFE_0001;
    i_addr    = 32'h500;
    wait_sig(0, 10, n);
    check("t5_addr", addr, 32'h500);
    wait_sig(1, 10, n);
    check("t5_i_rdata", i_rdata, 32'hCAFE_0001);
    check("t5_i_err", 32'(i_err), 32'd0);
    tick();
    i_req = 1'b0;

    // Back-to-back fetches with the address moving after each i_done.
    tick();
    i_addr   = 32'h600;
    i_req    = 1'b1;
    last_ads = 0;
    for (int j = 0; j < 4; j++) begin
      wait_sig(0, 10, n);
      check("t6_addr", addr, 32'h600 + 32'(4 * j));
      if (j > 0) check("t6_gap", 32'(cyc - last_ads), 32'd3);
      last_ads = cyc;
      wait_sig(1, 10, n);
      tick();
      if (j < 3) i_addr = i_addr + 32'd4;
      else i_req = 1'b0;
    end

    repeat (4) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
